// File: rtl/mem_req_queue.sv
// Latency-gated memory request FIFO: each entry becomes retireable only once
// LATENCY cycles have elapsed since it was enqueued (timestamped by a free-running counter).
module mem_req_queue #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 33,
    parameter int unsigned OP_W    = 2,
    parameter int unsigned LATENCY = 100,
    parameter int unsigned CNT_W   = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              in_op,
    input  logic [ADDR_W-1:0]            in_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OP_W-1:0]              out_op,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [CNT_W-1:0]             out_ts,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         full,
    output logic                         empty,
    output logic [CNT_W-1:0]             cycle,
    output logic [31:0]                  drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [OCC_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_cycle;
    logic [31:0]       r_drop;

    logic [OP_W-1:0]   r_op_mem   [DEPTH];
    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [CNT_W-1:0]  r_ts_mem   [DEPTH];

    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_age;
    logic              w_elig;
    logic              w_enq;
    logic              w_deq;
    logic [PTR_W-1:0]  w_head_nxt;
    logic [PTR_W-1:0]  w_tail_nxt;

    always_comb begin
        w_full     = (r_count == OCC_W'(DEPTH));
        w_empty    = (r_count == '0);
        // Modular subtraction keeps the age correct across counter wrap.
        w_age      = r_cycle - r_ts_mem[r_head];
        w_elig     = !w_empty && (w_age >= CNT_W'(LATENCY));
        w_enq      = in_valid && !w_full;
        w_deq      = w_elig && out_ready;
        w_head_nxt = (r_head == PTR_W'(DEPTH-1)) ? '0 : r_head + PTR_W'(1);
        w_tail_nxt = (r_tail == PTR_W'(DEPTH-1)) ? '0 : r_tail + PTR_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_cycle <= '0;
            r_drop  <= '0;
        end else begin
            r_cycle <= r_cycle + CNT_W'(1);
            if (w_enq) begin
                r_tail <= w_tail_nxt;
            end
            if (w_deq) begin
                r_head <= w_head_nxt;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
            if (in_valid && w_full && (r_drop != '1)) begin
                r_drop <= r_drop + 32'd1;
            end
        end
    end

    // Payload storage is intentionally left uncleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && w_enq) begin
            r_op_mem[r_tail]   <= in_op;
            r_addr_mem[r_tail] <= in_addr;
            r_ts_mem[r_tail]   <= r_cycle;
        end
    end

    always_comb begin
        in_ready  = !w_full;
        out_valid = w_elig;
        out_op    = r_op_mem[r_head];
        out_addr  = r_addr_mem[r_head];
        out_ts    = r_ts_mem[r_head];
        occupancy = r_count;
        full      = w_full;
        empty     = w_empty;
        cycle     = r_cycle;
        drop_cnt  = r_drop;
    end

endmodule
